// File: rtl/issue_pkg.sv
// Shared types for the dual-pipe issue queue: the decoded instruction bundle and pipe selector.
// Pure type/constant package; no timing or flow-control behaviour of its own.
package issue_pkg;

   localparam int XLEN         = 32;
   localparam int ALU_OP_W     = 4;
   localparam int LOAD_TYPE_W  = 3;
   localparam int STORE_TYPE_W = 2;
   localparam int BRANCH_W     = 3;
   localparam int REG_W        = 5;

   typedef enum logic {
      PIPE_A = 1'b0,
      PIPE_M = 1'b1
   } pipe_sel_e;

   typedef struct packed {
      logic [XLEN-1:0]         pc;
      logic [XLEN-1:0]         imm;
      logic                    imm_en;
      logic                    shift;
      logic [ALU_OP_W-1:0]     alu_op;
      logic [REG_W-1:0]        rs1;
      logic [REG_W-1:0]        rs2;
      logic [REG_W-1:0]        rd;
      logic                    rf_we;
      logic [LOAD_TYPE_W-1:0]  load_type;
      logic [STORE_TYPE_W-1:0] store_type;
      logic                    mem_re;
      logic                    mem_we;
      logic                    jal;
      logic                    jalr;
      logic [BRANCH_W-1:0]     branch_en;
   } issue_bundle_t;

   // Anything that touches memory must use pipe M.
   function automatic logic is_mem(input issue_bundle_t b);
      return (|b.load_type) | (|b.store_type);
   endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the two oldest queue entries may issue together and which pipe each takes.
// Combinational, zero latency; no flow control (the caller gates the result with stall/flush).
module issue_pair_check
   import issue_pkg::*;
(
   input  issue_bundle_t h0,
   input  issue_bundle_t h1,
   input  logic [1:0]    present,
   output logic          dual_ok,
   output pipe_sel_e     h0_pipe,
   output pipe_sel_e     h1_pipe
);

   logic h0_mem;
   logic h1_mem;
   logic raw;
   logic waw;
   logic h0_ctrl;
   logic unused_fields;

   always_comb begin
      h0_mem  = is_mem(h0);
      h1_mem  = is_mem(h1);
      // x0 is never a real dependency.
      raw     = h0.rf_we && (h0.rd != '0) && ((h1.rs1 == h0.rd) || (h1.rs2 == h0.rd));
      waw     = h0.rf_we && h1.rf_we && (h0.rd != '0) && (h0.rd == h1.rd);
      h0_ctrl = h0.jal | h0.jalr | (|h0.branch_en);

      dual_ok = (present == 2'd2) && !(h0_mem && h1_mem) && !raw && !waw && !h0_ctrl;

      h0_pipe = h0_mem ? PIPE_M : PIPE_A;
      // In a legal pair at most one is mem, so h1 takes whichever pipe h0 left free.
      h1_pipe = h0_mem ? PIPE_A : PIPE_M;
   end

   assign unused_fields = ^{h0, h1};

endmodule

// File: rtl/issue_steer_queue.sv
// In-order DEPTH-entry issue queue steering up to two instructions per cycle onto pipes A and M.
// Latency: enqueue edge t -> issue register at edge t+1; backpressure: in_ready low when <2 slots free, stall freezes issue.
module issue_steer_queue
   import issue_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 8,
   parameter int ALU_OP_W    = 4,
   parameter int LOAD_TYPE_W = 3,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [1:0]                 in_valid,
   output logic                       in_ready,
   input  issue_bundle_t [1:0]        in_bundle,
   input  logic                       stall,
   output logic                       a_valid,
   output issue_bundle_t              a_bundle,
   output logic                       m_valid,
   output issue_bundle_t              m_bundle,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           conflict_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   // The bundle layout is fixed by the package; reject overrides that disagree with it.
   if ((WIDTH != issue_pkg::XLEN) || (ALU_OP_W != issue_pkg::ALU_OP_W) ||
       (LOAD_TYPE_W != issue_pkg::LOAD_TYPE_W) || (DEPTH < 4) ||
       ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_params
      $error("issue_steer_queue: unsupported parameter set");
   end

   issue_bundle_t    mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] head_nxt1;
   logic [PTR_W-1:0] tail_nxt1;
   logic [OCC_W-1:0] occ;

   logic [1:0]       present;
   logic [1:0]       enq_cnt;
   logic [1:0]       deq_cnt;
   logic [1:0]       issue_deq;
   logic             issue_en;
   logic             single_issue;

   issue_bundle_t    h0;
   issue_bundle_t    h1;
   logic             dual_ok;
   pipe_sel_e        h0_pipe;
   pipe_sel_e        h1_pipe;

   logic             a_vld_nxt;
   logic             m_vld_nxt;
   issue_bundle_t    a_nxt;
   issue_bundle_t    m_nxt;

   assign in_ready  = (occ <= OCC_W'(DEPTH - 2));
   assign occupancy = occ;
   assign head_nxt1 = head + PTR_W'(1);
   assign tail_nxt1 = tail + PTR_W'(1);
   assign h0        = mem[head];
   assign h1        = mem[head_nxt1];
   assign present   = (occ >= OCC_W'(2)) ? 2'd2 : occ[1:0];
   assign issue_en  = !stall && !flush;

   issue_pair_check u_pair_check (
      .h0      (h0),
      .h1      (h1),
      .present (present),
      .dual_ok (dual_ok),
      .h0_pipe (h0_pipe),
      .h1_pipe (h1_pipe)
   );

   always_comb begin
      a_vld_nxt = 1'b0;
      m_vld_nxt = 1'b0;
      a_nxt     = '0;
      m_nxt     = '0;
      deq_cnt   = 2'd0;
      if (present != 2'd0) begin
         deq_cnt = 2'd1;
         if (h0_pipe == PIPE_M) begin
            m_vld_nxt = 1'b1;
            m_nxt     = h0;
         end else begin
            a_vld_nxt = 1'b1;
            a_nxt     = h0;
         end
         if (dual_ok) begin
            deq_cnt = 2'd2;
            if (h1_pipe == PIPE_M) begin
               m_vld_nxt = 1'b1;
               m_nxt     = h1;
            end else begin
               a_vld_nxt = 1'b1;
               a_nxt     = h1;
            end
         end
      end
   end

   always_comb begin
      enq_cnt = 2'd0;
      if (in_ready && in_valid[0]) begin
         enq_cnt = in_valid[1] ? 2'd2 : 2'd1;
      end
      issue_deq    = issue_en ? deq_cnt : 2'd0;
      single_issue = (present == 2'd2) && !dual_ok;
   end

   // Storage carries no reset; entries are only observed while counted in occ.
   always_ff @(posedge clk) begin
      if (!flush && (enq_cnt != 2'd0)) begin
         mem[tail] <= in_bundle[0];
         if (enq_cnt == 2'd2) begin
            mem[tail_nxt1] <= in_bundle[1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         tail <= tail + PTR_W'(enq_cnt);
         head <= head + PTR_W'(issue_deq);
         occ  <= occ + OCC_W'(enq_cnt) - OCC_W'(issue_deq);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid  <= 1'b0;
         m_valid  <= 1'b0;
         a_bundle <= '0;
         m_bundle <= '0;
      end else if (flush) begin
         a_valid  <= 1'b0;
         m_valid  <= 1'b0;
         a_bundle <= '0;
         m_bundle <= '0;
      end else if (!stall) begin
         a_valid  <= a_vld_nxt;
         m_valid  <= m_vld_nxt;
         a_bundle <= a_nxt;
         m_bundle <= m_nxt;
      end
   end

   // Counts lost dual-issue opportunities; survives flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (issue_en && single_issue && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule
